// File: rtl/serial_tx_block.sv
// Parallel-to-serial frame transmitter: start bit 0, DATA_BITS data bits LSB-first, stop bit 1,
// each bit held for BIT_PERIOD clocks. Every output comes straight from a register.
module serial_tx_block #(
    parameter int DATA_BITS  = 8,
    parameter int BIT_PERIOD = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   serial_q, serial_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    assign bit_end = (timer_q == TIMER_LAST);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        serial_d = serial_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        timer_d  = bit_end ? '0 : timer_q + 1'b1;

        case (state_q)
            IDLE: begin
                // Timer restarts at zero so the start bit lasts a full period.
                timer_d  = '0;
                idx_d    = '0;
                serial_d = 1'b1;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    state_d  = START;
                    serial_d = 1'b0;
                    ready_d  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    serial_d = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d  = STOP;
                        idx_d    = '0;
                        serial_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        serial_d = shift_d[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    done_d   = 1'b1;
                    serial_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                ready_d  = 1'b1;
                serial_d = 1'b1;
            end
        endcase

        busy_d = ~ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            timer_q  <= '0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready   = ready_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign serial_out = serial_q;

endmodule
